// File: rtl/fgmt_pkg.sv
// Shared types and defaults for the fine-grained multithreading front end.
package fgmt;

  localparam int DEF_NUM_THREADS = 4;
  localparam int DEF_WIDTH       = 32;
  localparam int DEF_PC_STEP     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } thr_state_e;

endpackage

// File: rtl/thread_pc_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// searching upward from the slot after the previous grant, with wrap.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_valid
);

  logic [IW-1:0] cand;

  // Walk the N slots starting at last_idx+1; the final step wraps back to last_idx itself
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = last_idx + IW'(k);
      if (!any_valid && req[cand]) begin
        any_valid       = 1'b1;
        grant_idx       = cand;
        grant[cand]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/thread_pc_scheduler.sv
// Per-thread PC holder and round-robin fetch selector with start/halt
// control and a one-deep registered branch-redirect stage.
module thread_pc_scheduler
  import fgmt::*;
#(
  parameter int               NUM_THREADS = DEF_NUM_THREADS,
  parameter int               WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int               PC_STEP     = DEF_PC_STEP,
  localparam int              TID_W       = $clog2(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   fetch_ready,
  output logic                   fetch_valid,
  output logic [WIDTH-1:0]       fetch_pc,
  output logic [TID_W-1:0]       fetch_tid,
  input  logic                   br_taken,
  input  logic [TID_W-1:0]       br_tid,
  input  logic [WIDTH-1:0]       br_addr,
  input  logic                   thr_start,
  input  logic [TID_W-1:0]       start_tid,
  input  logic [WIDTH-1:0]       start_pc,
  input  logic                   thr_halt,
  input  logic [TID_W-1:0]       halt_tid,
  output logic [NUM_THREADS-1:0] thread_active
);

  logic [WIDTH-1:0]       pc_vec [NUM_THREADS];
  logic [NUM_THREADS-1:0] run_vec;
  logic [NUM_THREADS-1:0] grant;
  logic [TID_W-1:0]       grant_idx;
  logic [TID_W-1:0]       last_tid;
  logic                   any_run;
  logic                   fire;

  logic                   br_q_valid;
  logic [TID_W-1:0]       br_q_tid;
  logic [WIDTH-1:0]       br_q_addr;
  logic                   start_masks_br;

  rr_arbiter #(
    .N(NUM_THREADS)
  ) u_arb (
    .req       (run_vec),
    .last_idx  (last_tid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_run)
  );

  assign fire        = any_run & fetch_ready;
  assign fetch_valid = any_run;
  assign fetch_tid   = grant_idx;
  assign fetch_pc    = any_run ? pc_vec[grant_idx] : '0;

  // A start wins over a branch on the same thread, so that branch never enters the stage;
  // a halt on that thread cancels the start and lets the branch through again
  assign start_masks_br = thr_start && (start_tid == br_tid) && !(thr_halt && (halt_tid == start_tid));

  // Round-robin pointer follows accepted fetches; the redirect stage captures every unmasked branch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_tid   <= TID_W'(NUM_THREADS - 1);
      br_q_valid <= 1'b0;
      br_q_tid   <= '0;
      br_q_addr  <= '0;
    end else begin
      if (fire) begin
        last_tid <= grant_idx;
      end
      br_q_valid <= br_taken && !start_masks_br;
      br_q_tid   <= br_tid;
      br_q_addr  <= br_addr;
    end
  end

  for (genvar g = 0; g < NUM_THREADS; g++) begin : g_thr
    localparam logic [TID_W-1:0] MY_TID    = TID_W'(g);
    localparam thr_state_e       RST_STATE = (g == 0) ? RUN : IDLE;

    thr_state_e       state_q;
    thr_state_e       state_d;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic             halt_hit;
    logic             start_hit;
    logic             cap_hit;
    logic             wr_hit;
    logic             fire_hit;

    assign halt_hit  = thr_halt && (halt_tid == MY_TID);
    assign start_hit = thr_start && (start_tid == MY_TID) && !halt_hit;
    assign cap_hit   = br_taken && (br_tid == MY_TID);
    assign wr_hit    = br_q_valid && (br_q_tid == MY_TID);
    assign fire_hit  = fire && grant[g];

    // Next state/PC with priority halt > start > redirect write > fetch increment
    always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (halt_hit) begin
        state_d = IDLE;
        if (wr_hit) begin
          pc_d = br_q_addr;
        end
      end else if (start_hit) begin
        state_d = RUN;
        pc_d    = start_pc;
      end else begin
        if (wr_hit) begin
          pc_d = br_q_addr;
        end else if (fire_hit) begin
          pc_d = pc_q + WIDTH'(PC_STEP);
        end
        if (cap_hit && (state_q != IDLE)) begin
          state_d = REDIR;
        end else if (wr_hit && (state_q == REDIR)) begin
          state_d = RUN;
        end
      end
    end

    // Thread state and PC registers; only thread 0 comes out of reset running
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= RST_STATE;
        pc_q    <= RESET_PC;
      end else begin
        state_q <= state_d;
        pc_q    <= pc_d;
      end
    end

    assign pc_vec[g]        = pc_q;
    assign run_vec[g]       = (state_q == RUN);
    assign thread_active[g] = (state_q != IDLE);
  end

endmodule

// File: tb/tb_thread_pc_scheduler.sv
// Bench for thread_pc_scheduler: a 4-thread instance checked cycle by
// cycle against a behavioural model through a scoreboard queue, plus an
// 8-thread 16-bit instance for PC wrap and mid-redirect reset.
module tb_thread_pc_scheduler;

  logic        clk;
  logic        reset_n;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [1:0]  fetch_tid;
  logic        br_taken;
  logic [1:0]  br_tid;
  logic [31:0] br_addr;
  logic        thr_start;
  logic [1:0]  start_tid;
  logic [31:0] start_pc;
  logic        thr_halt;
  logic [1:0]  halt_tid;
  logic [3:0]  thread_active;

  logic        rst8_n;
  logic        ready8;
  logic        valid8;
  logic [15:0] pc8;
  logic [2:0]  tid8;
  logic        br8;
  logic [2:0]  br8_tid;
  logic [15:0] br8_addr;
  logic        st8;
  logic [2:0]  st8_tid;
  logic [15:0] st8_pc;
  logic        h8;
  logic [2:0]  h8_tid;
  logic [7:0]  active8;

  int n_checks;
  int n_pass;

  typedef struct {
    logic        valid;
    logic [1:0]  tid;
    logic [31:0] pc;
    logic [3:0]  active;
  } exp_t;

  exp_t sb_q[$];

  // model state: 0 = idle, 1 = run, 2 = redirect pending
  int          m_state [4];
  logic [31:0] m_pc    [4];
  int          m_last;
  bit          m_bv;
  int          m_bt;
  logic [31:0] m_ba;

  thread_pc_scheduler dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fetch_ready   (fetch_ready),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc),
    .fetch_tid     (fetch_tid),
    .br_taken      (br_taken),
    .br_tid        (br_tid),
    .br_addr       (br_addr),
    .thr_start     (thr_start),
    .start_tid     (start_tid),
    .start_pc      (start_pc),
    .thr_halt      (thr_halt),
    .halt_tid      (halt_tid),
    .thread_active (thread_active)
  );

  thread_pc_scheduler #(
    .NUM_THREADS (8),
    .WIDTH       (16)
  ) dut8 (
    .clk           (clk),
    .reset_n       (rst8_n),
    .fetch_ready   (ready8),
    .fetch_valid   (valid8),
    .fetch_pc      (pc8),
    .fetch_tid     (tid8),
    .br_taken      (br8),
    .br_tid        (br8_tid),
    .br_addr       (br8_addr),
    .thr_start     (st8),
    .start_tid     (st8_tid),
    .start_pc      (st8_pc),
    .thr_halt      (h8),
    .halt_tid      (h8_tid),
    .thread_active (active8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 4; i++) begin
      m_state[i] = (i == 0) ? 1 : 0;
      m_pc[i]    = 32'h0;
    end
    m_last = 3;
    m_bv   = 1'b0;
    m_bt   = 0;
    m_ba   = 32'h0;
  endtask

  function automatic exp_t predict();
    exp_t e;
    int   idx;
    e.valid  = 1'b0;
    e.tid    = 2'd0;
    e.pc     = 32'h0;
    e.active = 4'h0;
    for (int i = 0; i < 4; i++) begin
      e.active[i] = (m_state[i] != 0);
    end
    for (int k = 1; k <= 4; k++) begin
      idx = (m_last + k) % 4;
      if (!e.valid && m_state[idx] == 1) begin
        e.valid = 1'b1;
        e.tid   = 2'(idx);
        e.pc    = m_pc[idx];
      end
    end
    return e;
  endfunction

  task automatic modelStep();
    exp_t        e;
    bit          fired;
    bit          halted;
    bit          started;
    bit          wrote;
    int          ns [4];
    logic [31:0] np [4];
    e     = predict();
    fired = e.valid && fetch_ready;
    for (int i = 0; i < 4; i++) begin
      halted  = thr_halt && (halt_tid == 2'(i));
      started = thr_start && (start_tid == 2'(i)) && !halted;
      wrote   = m_bv && (m_bt == i);
      ns[i]   = m_state[i];
      np[i]   = m_pc[i];
      if (halted) begin
        ns[i] = 0;
        if (wrote) np[i] = m_ba;
      end else if (started) begin
        ns[i] = 1;
        np[i] = start_pc;
      end else begin
        if (wrote) np[i] = m_ba;
        else if (fired && e.tid == 2'(i)) np[i] = m_pc[i] + 32'd4;
        if (br_taken && br_tid == 2'(i) && m_state[i] != 0) ns[i] = 2;
        else if (wrote && m_state[i] == 2) ns[i] = 1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      m_state[i] = ns[i];
      m_pc[i]    = np[i];
    end
    if (fired) m_last = int'(e.tid);
    m_bv = br_taken && !(thr_start && start_tid == br_tid && !(thr_halt && halt_tid == br_tid));
    m_bt = int'(br_tid);
    m_ba = br_addr;
  endtask

  task automatic applyStimulus(input bit rdy, input bit bt, input logic [1:0] btid, input logic [31:0] ba,
                               input bit st, input logic [1:0] stid, input logic [31:0] spc,
                               input bit h, input logic [1:0] htid);
    exp_t e;
    fetch_ready = rdy;
    br_taken    = bt;
    br_tid      = btid;
    br_addr     = ba;
    thr_start   = st;
    start_tid   = stid;
    start_pc    = spc;
    thr_halt    = h;
    halt_tid    = htid;
    sb_q.push_back(predict());
    #1;
    e = sb_q.pop_front();
    checkOutput("valid", 32'(fetch_valid), 32'(e.valid));
    checkOutput("tid", 32'(fetch_tid), 32'(e.tid));
    checkOutput("pc", fetch_pc, e.pc);
    checkOutput("active", 32'(thread_active), 32'(e.active));
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    reset_n     = 1'b0;
    fetch_ready = 1'b0;
    br_taken    = 1'b0;
    br_tid      = 2'd0;
    br_addr     = 32'h0;
    thr_start   = 1'b0;
    start_tid   = 2'd0;
    start_pc    = 32'h0;
    thr_halt    = 1'b0;
    halt_tid    = 2'd0;
    rst8_n      = 1'b0;
    ready8      = 1'b0;
    br8         = 1'b0;
    br8_tid     = 3'd0;
    br8_addr    = 16'h0;
    st8         = 1'b0;
    st8_tid     = 3'd0;
    st8_pc      = 16'h0;
    h8          = 1'b0;
    h8_tid      = 3'd0;
    resetModel();

    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("rst_valid", 32'(fetch_valid), 32'h1);
    checkOutput("rst_tid", 32'(fetch_tid), 32'h0);
    checkOutput("rst_pc", fetch_pc, 32'h0);
    checkOutput("rst_active", 32'(thread_active), 32'h1);

    // thread 0 alone streams 0,4,8
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("t0_pc_after3", fetch_pc, 32'hC);

    // start threads 1 and 3 while fetch is stalled
    applyStimulus(0, 0, 0, 0, 1, 2'd1, 32'h100, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 2'd3, 32'h300, 0, 0);
    #1 checkOutput("t1_first_tid", 32'(fetch_tid), 32'h1);
    checkOutput("t1_first_pc", fetch_pc, 32'h100);
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("t1_second_pc", fetch_pc, 32'h104);
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // stall holds the presented thread and PC
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("stall_tid", 32'(fetch_tid), 32'h1);
    checkOutput("stall_pc", fetch_pc, 32'h108);

    // redirect thread 1 to 0x800
    applyStimulus(1, 1, 2'd1, 32'h800, 0, 0, 0, 0, 0);
    #1 checkOutput("redir_skip_tid", 32'(fetch_tid), 32'h3);
    checkOutput("redir_active", 32'(thread_active), 32'hB);
    repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("redir_tid", 32'(fetch_tid), 32'h1);
    checkOutput("redir_pc", fetch_pc, 32'h800);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // halt, start and branch on thread 0 in one cycle: halt wins
    applyStimulus(0, 1, 2'd0, 32'h900, 1, 2'd0, 32'h40, 1, 2'd0);
    #1 checkOutput("collide_active", 32'(thread_active), 32'hA);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // random mix of all controls against the model
    for (int c = 0; c < 120; c++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)), $urandom,
                    $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), $urandom,
                    $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)));
    end

    // 8-thread 16-bit instance: wrap and mid-redirect reset
    rst8_n = 1'b1;
    #1;
    checkOutput("w_rst_valid", 32'(valid8), 32'h1);
    checkOutput("w_rst_pc", 32'(pc8), 32'h0);
    checkOutput("w_rst_active", 32'(active8), 32'h01);
    st8     = 1'b1;
    st8_tid = 3'd0;
    st8_pc  = 16'hFFFC;
    @(posedge clk);
    @(negedge clk);
    st8    = 1'b0;
    ready8 = 1'b1;
    #1 checkOutput("w_start_pc", 32'(pc8), 32'hFFFC);
    @(posedge clk);
    @(negedge clk);
    #1 checkOutput("w_wrap_pc", 32'(pc8), 32'h0000);
    checkOutput("w_wrap_tid", 32'(tid8), 32'h0);
    br8      = 1'b1;
    br8_tid  = 3'd0;
    br8_addr = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    br8 = 1'b0;
    #1 checkOutput("w_redir_valid", 32'(valid8), 32'h0);
    #2 rst8_n = 1'b0;
    #1 checkOutput("w_mid_rst_active", 32'(active8), 32'h01);
    checkOutput("w_mid_rst_pc", 32'(pc8), 32'h0);
    @(negedge clk);
    rst8_n = 1'b1;
    #1 checkOutput("w_post_rst_pc", 32'(pc8), 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1 checkOutput("w_no_redir_pc", 32'(pc8), 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
